// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with registered result/flags, persistent carry for ADC/SBB and a 16-op set.
// Build option ALU_SEQ_MUL_EN adds the iterative shift-add multiplier on op 14 (illegal op otherwise).
//
// state    | meaning
// IDLE     | accepting ops; single-cycle ops load the output register on accept
// MUL_BUSY | shift-add multiply in progress, one iteration per cycle, input blocked
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             negative,
    output logic             overflow,
    output logic             err
);

    localparam int MSB = WIDTH - 1;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_NOT   = 4'd5;
    localparam logic [3:0] OP_SHL   = 4'd6;
    localparam logic [3:0] OP_SHR   = 4'd7;
    localparam logic [3:0] OP_ADC   = 4'd8;
    localparam logic [3:0] OP_SBB   = 4'd9;
    localparam logic [3:0] OP_SRA   = 4'd10;
    localparam logic [3:0] OP_ROL   = 4'd11;
    localparam logic [3:0] OP_ROR   = 4'd12;
    localparam logic [3:0] OP_CMP   = 4'd13;
    localparam logic [3:0] OP_MUL   = 4'd14;
    localparam logic [3:0] OP_PASSB = 4'd15;

    logic             carry_q;
    logic             accept;
    logic             out_free;
    logic             single_load;
    logic             mul_done;
    logic [WIDTH-1:0] mul_res;
    logic             mul_c;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   dif;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] flag_src;
    logic             alu_c;
    logic             alu_v;
    logic             alu_err;

    assign out_free = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // Arithmetic runs WIDTH+1 wide so bit WIDTH is the carry-out / borrow.
    always_comb begin
        sum      = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, (op == OP_ADC) && carry_q};
        dif      = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, (op == OP_SBB) && carry_q};
        alu_res  = '0;
        alu_c    = 1'b0;
        alu_v    = 1'b0;
        alu_err  = 1'b0;
        case (op)
            OP_ADD, OP_ADC: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
            end
            OP_SUB, OP_SBB: begin
                alu_res = dif[WIDTH-1:0];
                alu_c   = dif[WIDTH];
                alu_v   = (a[MSB] != b[MSB]) && (dif[MSB] != a[MSB]);
            end
            OP_CMP: begin
                alu_res = a;
                alu_c   = dif[WIDTH];
                alu_v   = (a[MSB] != b[MSB]) && (dif[MSB] != a[MSB]);
            end
            OP_AND:   alu_res = a & b;
            OP_OR:    alu_res = a | b;
            OP_XOR:   alu_res = a ^ b;
            OP_NOT:   alu_res = ~a;
            OP_SHL: begin
                alu_res = {a[WIDTH-2:0], 1'b0};
                alu_c   = a[MSB];
            end
            OP_SHR: begin
                alu_res = {1'b0, a[WIDTH-1:1]};
                alu_c   = a[0];
            end
            OP_SRA: begin
                alu_res = {a[MSB], a[WIDTH-1:1]};
                alu_c   = a[0];
            end
            OP_ROL: begin
                alu_res = {a[WIDTH-2:0], a[MSB]};
                alu_c   = a[MSB];
            end
            OP_ROR: begin
                alu_res = {a[0], a[WIDTH-1:1]};
                alu_c   = a[0];
            end
            OP_PASSB: alu_res = b;
            OP_MUL:   alu_err = 1'b1;
        endcase
        flag_src = (op == OP_CMP) ? dif[WIDTH-1:0] : alu_res;
    end

`ifdef ALU_SEQ_MUL_EN
    localparam logic [0:0] S_IDLE     = 1'b0;
    localparam logic [0:0] S_MUL_BUSY = 1'b1;
    localparam int         CW         = $clog2(WIDTH);

    logic [0:0]         state;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH:0]     psum;
    logic [2*WIDTH-1:0] acc_nxt;
    logic               mul_start;
    logic               mul_step;

    // acc = {partial product, remaining multiplier bits}; each step adds then shifts right.
    assign psum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
    assign acc_nxt = {psum, acc[WIDTH-1:1]};
    assign mul_res = acc_nxt[WIDTH-1:0];
    assign mul_c   = |acc_nxt[2*WIDTH-1:WIDTH];

    assign in_ready    = (state == S_IDLE) && out_free;
    assign mul_start   = accept && (op == OP_MUL);
    assign single_load = accept && (op != OP_MUL);
    // The last iteration stalls until the output register can take its result.
    assign mul_step    = (state == S_MUL_BUSY) && ((cnt != '0) || out_free);
    assign mul_done    = mul_step && (cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            acc   <= '0;
            mcand <= '0;
        end else if (mul_start) begin
            state <= S_MUL_BUSY;
            cnt   <= CW'(WIDTH - 1);
            acc   <= {{WIDTH{1'b0}}, b};
            mcand <= a;
        end else if (mul_step) begin
            acc <= acc_nxt;
            cnt <= cnt - CW'(1);
            if (cnt == '0) begin
                state <= S_IDLE;
            end
        end
    end
`else
    assign in_ready    = out_free;
    assign single_load = accept;
    assign mul_done    = 1'b0;
    assign mul_res     = '0;
    assign mul_c       = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            carry     <= 1'b0;
            negative  <= 1'b0;
            overflow  <= 1'b0;
            err       <= 1'b0;
            carry_q   <= 1'b0;
        end else if (single_load) begin
            out_valid <= 1'b1;
            result    <= alu_res;
            zero      <= (flag_src == '0);
            carry     <= alu_c;
            negative  <= flag_src[MSB];
            overflow  <= alu_v;
            err       <= alu_err;
            if (!alu_err) begin
                carry_q <= alu_c;
            end
        end else if (mul_done) begin
            out_valid <= 1'b1;
            result    <= mul_res;
            zero      <= (mul_res == '0);
            carry     <= mul_c;
            negative  <= mul_res[MSB];
            overflow  <= 1'b0;
            err       <= 1'b0;
            carry_q   <= mul_c;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=8; expected values are hand-computed constants.
module tb_alu_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         zero;
    logic         carry;
    logic         negative;
    logic         overflow;
    logic         err;

    int tests = 0;
    int fails = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .carry     (carry),
        .negative  (negative),
        .overflow  (overflow),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [W-1:0] r, input logic z, input logic c,
                           input logic n, input logic v, input logic e);
        chk({tag, "/valid"}, 64'(out_valid), 64'(1'b1));
        chk({tag, "/res"},   64'(result),    64'(r));
        chk({tag, "/z"},     64'(zero),      64'(z));
        chk({tag, "/c"},     64'(carry),     64'(c));
        chk({tag, "/n"},     64'(negative),  64'(n));
        chk({tag, "/v"},     64'(overflow),  64'(v));
        chk({tag, "/err"},   64'(err),       64'(e));
    endtask

    // Called at posedge+1; presents one op for exactly one edge.
    task automatic send(input string tag, input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        op = o;
        a = x;
        b = y;
        in_valid = 1'b1;
        chk({tag, "/in_ready"}, 64'(in_ready), 64'(1'b1));
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "bench did not finish");
    end

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        a = '0;
        b = '0;
        op = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst/valid", 64'(out_valid), 64'(1'b0));
        chk("rst/res", 64'(result), 64'(0));
        chk("rst/flags", 64'({zero, carry, negative, overflow, err}), 64'(0));
        chk("rst/in_ready", 64'(in_ready), 64'(1'b1));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        send("add_ff", 4'd0, 8'hFF, 8'h01);  chk_out("add_ff", 8'h00, 1, 1, 0, 0, 0);
        send("adc_b2b", 4'd8, 8'h00, 8'h00); chk_out("adc_b2b", 8'h01, 0, 0, 0, 0, 0);
        send("sub", 4'd1, 8'h50, 8'h70);     chk_out("sub", 8'hE0, 0, 1, 1, 0, 0);
        send("add_ov", 4'd0, 8'h7F, 8'h01);  chk_out("add_ov", 8'h80, 0, 0, 1, 1, 0);
        send("cmp_eq", 4'd13, 8'h33, 8'h33); chk_out("cmp_eq", 8'h33, 1, 0, 0, 0, 0);
        send("sub_bw", 4'd1, 8'h00, 8'h01);  chk_out("sub_bw", 8'hFF, 0, 1, 1, 0, 0);
        send("sbb", 4'd9, 8'h10, 8'h00);     chk_out("sbb", 8'h0F, 0, 0, 0, 0, 0);
        send("shl", 4'd6, 8'h81, 8'h00);     chk_out("shl", 8'h02, 0, 1, 0, 0, 0);
        send("shr", 4'd7, 8'h01, 8'h00);     chk_out("shr", 8'h00, 1, 1, 0, 0, 0);
        send("sra", 4'd10, 8'h81, 8'h00);    chk_out("sra", 8'hC0, 0, 1, 1, 0, 0);
        send("rol", 4'd11, 8'h80, 8'h00);    chk_out("rol", 8'h01, 0, 1, 0, 0, 0);
        send("ror", 4'd12, 8'h01, 8'h00);    chk_out("ror", 8'h80, 0, 1, 1, 0, 0);
        send("not", 4'd5, 8'h0F, 8'h00);     chk_out("not", 8'hF0, 0, 0, 1, 0, 0);
        send("xor", 4'd4, 8'hFF, 8'h0F);     chk_out("xor", 8'hF0, 0, 0, 1, 0, 0);
        send("or", 4'd3, 8'h0A, 8'h05);      chk_out("or", 8'h0F, 0, 0, 0, 0, 0);
        send("passb", 4'd15, 8'h11, 8'h5A);  chk_out("passb", 8'h5A, 0, 0, 0, 0, 0);
        send("cmp_lt", 4'd13, 8'h10, 8'h20); chk_out("cmp_lt", 8'h10, 0, 1, 1, 0, 0);

`ifdef ALU_SEQ_MUL_EN
        send("mul", 4'd14, 8'h12, 8'h10);
        chk("mul/busy_valid0", 64'(out_valid), 64'(1'b0));
        chk("mul/busy_ready0", 64'(in_ready), 64'(1'b0));
        repeat (7) begin
            @(posedge clk);
            #1;
            chk("mul/iter_valid", 64'(out_valid), 64'(1'b0));
            chk("mul/iter_ready", 64'(in_ready), 64'(1'b0));
        end
        @(posedge clk);
        #1;
        chk_out("mul", 8'h20, 0, 1, 0, 0, 0);

        send("mul_rst", 4'd14, 8'h03, 8'h05);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("mul_rst/valid", 64'(out_valid), 64'(1'b0));
        chk("mul_rst/in_ready", 64'(in_ready), 64'(1'b1));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("mul_rst/no_result", 64'(out_valid), 64'(1'b0));
        send("add_after_rst", 4'd0, 8'h01, 8'h02);
        chk_out("add_after_rst", 8'h03, 0, 0, 0, 0, 0);
`else
        send("add_c", 4'd0, 8'hFF, 8'h01);   chk_out("add_c", 8'h00, 1, 1, 0, 0, 0);
        send("mul_ill", 4'd14, 8'h12, 8'h10); chk_out("mul_ill", 8'h00, 1, 0, 0, 0, 1);
        send("adc_keep", 4'd8, 8'h00, 8'h00); chk_out("adc_keep", 8'h01, 0, 0, 0, 0, 0);
`endif

        // Backpressure: second op must wait and land exactly once.
        @(posedge clk);
        #1;
        chk("bp/drained", 64'(out_valid), 64'(1'b0));
        out_ready = 1'b0;
        send("bp_and", 4'd2, 8'hF0, 8'h3C);
        chk_out("bp_and", 8'h30, 0, 0, 0, 0, 0);
        chk("bp/in_ready0", 64'(in_ready), 64'(1'b0));
        op = 4'd3;
        a = 8'h01;
        b = 8'h02;
        in_valid = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("bp/hold_res", 64'(result), 64'(8'h30));
            chk("bp/hold_valid", 64'(out_valid), 64'(1'b1));
            chk("bp/hold_ready", 64'(in_ready), 64'(1'b0));
        end
        out_ready = 1'b1;
        #1;
        chk("bp/ready_comb", 64'(in_ready), 64'(1'b1));
        @(posedge clk);
        #1 in_valid = 1'b0;
        chk_out("bp_or", 8'h03, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        chk("bp/no_dup", 64'(out_valid), 64'(1'b0));

        // Async reset mid-stream while a result is held, and carry_q cleared.
        send("pre_rst", 4'd0, 8'hFF, 8'h01);
        chk_out("pre_rst", 8'h00, 1, 1, 0, 0, 0);
        out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst/valid", 64'(out_valid), 64'(1'b0));
        chk("arst/res", 64'(result), 64'(0));
        chk("arst/flags", 64'({zero, carry, negative, overflow, err}), 64'(0));
        chk("arst/in_ready", 64'(in_ready), 64'(1'b1));
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        send("adc_cq0", 4'd8, 8'h00, 8'h00);
        chk_out("adc_cq0", 8'h00, 1, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, handshaked successor to the team's small combinational ALU. It has a registered result and flags, a persistent carry flag for multi-word arithmetic (ADC/SBB), and an extended 16-op set. An optional iterative multiplier is included. It sits between the operand-fetch stage and writeback in the datapath experiments, and is the timing-characterisation target for the W=4…64 sweep.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 4..64.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operands/op presented
in_ready  out  1  block can accept an op this cycle
a  in  WIDTH  operand A
b  in  WIDTH  operand B
op  in  4  opcode
out_valid  out  1  result/flags valid
out_ready  in  1  consumer takes result
result  out  WIDTH  registered result
zero  out  1  result (or compare difference) == 0
carry  out  1  carry/borrow/shifted-out bit
negative  out  1  MSB of result (or compare difference)
overflow  out  1  signed overflow
err  out  1  illegal op (MUL when not compiled in)

Behaviour:
- Reset (async assert, sync release): out_valid=0, result=0, all flags=0, err=0, internal carry_q=0, FSM=IDLE. Consequently in_ready=1 after reset.
- Accept: in_valid && in_ready at a rising edge.
- in_ready = (state==IDLE) && (!out_valid || out_ready). This is combinational and allows back-to-back issue at full rate.
- Output register holds result, flags and err stable while out_valid && !out_ready. It clears out_valid on out_ready only if no new result is loaded in the same edge.
- Single-cycle ops: accept at edge k, so out_valid=1 after edge k.
- Opcodes:
  - 0 ADD: a+b
  - 1 SUB: a−b
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 NOT a
  - 6 SHL a by 1
  - 7 SHR a by 1 (logical)
  - 8 ADC: a+b+carry_q
  - 9 SBB: a−b−carry_q
  - 10 SRA (arithmetic right by 1)
  - 11 ROL by 1
  - 12 ROR by 1
  - 13 CMP
  - 14 MUL
  - 15 PASSB
- Arithmetic in WIDTH+1 bits. Result is truncated to WIDTH.
- carry:
  - ADD/ADC: carry-out.
  - SUB/SBB/CMP: borrow (1 when the unsigned subtrahend exceeds the minuend).
  - Shifts/rotates: bit shifted out.
  - Logic ops/PASSB: 0.
  - MUL: 1 if upper WIDTH bits of the 2·WIDTH product are nonzero.
- overflow: signed overflow for ADD/SUB/ADC/SBB/CMP; 0 otherwise.
- negative = MSB. zero = (value==0).
- CMP: result=a unchanged. zero/negative/carry/overflow are taken from a−b.
- carry_q updates to the emitted carry on every accepted op when its result loads. ADC/SBB read the carry_q value that existed before their own accept.
- An ADC/SBB issued back-to-back after ADD uses the ADD carry. carry_q is bypassed from the output-stage load and is never stale.
- FSM states: IDLE, MUL_BUSY.
  - MUL accepted: IDLE→MUL_BUSY, in_ready=0.
  - MUL_BUSY runs WIDTH shift-add iterations, one per cycle, on a 2·WIDTH accumulator.
  - On the final iteration the result (low WIDTH bits) loads: out_valid rises WIDTH edges after the accept edge, and the FSM returns to IDLE.
  - If the output register is still full and unacknowledged at the final iteration, MUL_BUSY holds until out_ready, then loads.
- MUL flags: zero/negative from the low result, carry as above, overflow=0.
- Reset mid-MUL aborts the operation: state IDLE, accumulator discarded, no result emitted.
- in_valid while in_ready=0 is ignored. The source must hold it.

Optional Feature:
ALU_SEQ_MUL_EN
- Defined: op 14 is the iterative multiplier described above, and the MUL_BUSY state exists.
- Undefined: MUL_BUSY and the accumulator are not built. op 14 is a single-cycle illegal op: result=0, zero=1, carry=0, negative=0, overflow=0, err=1. carry_q is unchanged.
- err=0 for all other ops in both builds.

Test Plan:
1. Reset with rst_n=0 mid-stream, async → out_valid=0, result=0, all flags=0, in_ready=1 before the next clk edge.
2. WIDTH=8: ADD 0xFF+0x01 → result 0x00, zero=1, carry=1. Then back-to-back ADC 0x00+0x00 → result 0x01, carry=0.
3. SUB 0x50−0x70 → 0xE0, carry=1, negative=1, overflow=0. ADD 0x7F+0x01 → 0x80, overflow=1, negative=1. CMP 0x33,0x33 → result 0x33, zero=1.
4. Backpressure: out_ready=0, issue AND 0xF0&0x3C (→0x30) → in_ready drops, a second op is held, 0x30 stays stable for 5 cycles. out_ready=1 → second result appears on the next edge, with no loss or duplication.
5. With ALU_SEQ_MUL_EN: MUL 0x12×0x10 → result 0x20, carry=1, out_valid exactly 8 edges after accept, in_ready=0 throughout. Without the macro → result 0x00, zero=1, err=1 after 1 edge.
6. With ALU_SEQ_MUL_EN: assert rst_n=0 at iteration 4 of a MUL → no out_valid. A subsequent ADD 0x01+0x02 → 0x03 after 1 edge.
